wb_ram_arbiter: RTL and testbench
=================================

// Module: wb_ram_arbiter
// PURPOSE
//  Round-robin Wishbone B3 arbiter sharing one slave port (SoC RAM) between
//  up to NUM_MASTERS masters: CPU instruction bus, CPU data bus, and the
//  testbench RAM loader/debug master. Holds a grant for a whole cycle (cyc_i),
//  including bursts. An optional watchdog aborts stalled transfers with err.
// PARAMETERS
//  NUM_MASTERS  3   number of requesting masters (2..8)
//  AW           32  address width
//  DW           32  data width
//  TIMEOUT      0   stb-to-ack watchdog limit in cycles; 0 disables it
// PORTS
//  clk        in   1             system clock, all logic on rising edge
//  rst_n      in   1             asynchronous, active-low reset
//  m_adr_i    in   NUM_MASTERS*AW  master addresses, master k at [k*AW +: AW]
//  m_dat_i    in   NUM_MASTERS*DW  master write data
//  m_sel_i    in   NUM_MASTERS*DW/8 byte selects
//  m_we_i     in   NUM_MASTERS   write enables
//  m_cyc_i    in   NUM_MASTERS   cycle requests
//  m_stb_i    in   NUM_MASTERS   strobes
//  m_cti_i    in   NUM_MASTERS*3 cycle type ids
//  m_bte_i    in   NUM_MASTERS*2 burst type extensions
//  m_dat_o    out  DW            read data, broadcast to all masters
//  m_ack_o    out  NUM_MASTERS   ack, granted master only
//  m_err_o    out  NUM_MASTERS   err, granted master only (slave err or watchdog)
//  m_rty_o    out  NUM_MASTERS   retry, granted master only
//  s_adr_o/s_dat_o/s_sel_o/s_we_o/s_cti_o/s_bte_o  out  slave request fields
//  s_cyc_o, s_stb_o  out  1      slave cycle/strobe
//  s_dat_i    in   DW            slave read data
//  s_ack_i, s_err_i, s_rty_i  in  1  slave terminations
//  grant_o    out  NUM_MASTERS   one-hot current grant (0 when idle)
// BEHAVIOUR
//  - Reset: FSM=IDLE, grant_o=0, s_cyc_o=s_stb_o=0, all m_ack/err/rty_o=0,
//    watchdog=0, last-grant pointer=NUM_MASTERS-1 (master 0 wins first).
//  - FSM states:
//    IDLE:  if any m_cyc_i high, register a one-hot grant to the first requester
//           searching from last+1 upward, wrapping -> GRANT. Grant is visible
//           the next cycle (1-cycle arbitration latency).
//    GRANT: route the granted master's fields to s_*; s_cyc_o=m_cyc_i[g],
//           s_stb_o=m_stb_i[g]; s_ack/err/rty_i go only to bit g. Ungranted
//           masters see ack/err/rty=0. When m_cyc_i[g] falls -> IDLE, clear the
//           grant, update last=g. One idle turnaround cycle always follows.
//    ABORT: entered when the watchdog fires. s_cyc_o=s_stb_o=0. Stay until
//           m_cyc_i[g] falls -> IDLE.
//  - Routing mux is combinational from the registered grant. Field outputs are
//    don't-care but forced to 0 when idle, so no X propagates.
//  - Watchdog (TIMEOUT>0): counter clears on any s_ack/err/rty_i or when
//    s_stb_o=0, and increments while s_stb_o=1 without termination. When it
//    reaches TIMEOUT, m_err_o[g] pulses for exactly 1 cycle with s_cyc_o=0 in
//    that cycle, then go to ABORT. A slave ack arriving in the same cycle wins:
//    no err. The counter saturates and never wraps.
//  - Bursts (cti=001/010) and back-to-back stb keep the grant; only cyc drop
//    releases it. A stb drop inside a cycle does not release the grant.
//  - A requester dropping cyc before it is granted is simply skipped. A grant
//    that becomes stale (cyc low on the grant cycle) releases next cycle.
//  - Async reset mid-transfer: all outputs drop to 0 immediately, regardless
//    of the clock.
// TESTING
//  1. Reset: rst_n=0 with m_cyc_i=3'b111 -> grant_o=0, s_cyc_o=0. After release,
//     master0 is granted 1 cycle later.
//  2. Contention: all 3 hold cyc for single reads, each dropping cyc after ack
//     -> grant order 0,1,2,0 with 1 idle cycle between grants.
//  3. Burst: master1 4-beat incrementing burst (cti 010,010,010,111) while
//     master0 requests -> master1 keeps the grant for all 4 acks, then master0.
//  4. Routing: master2 writes 0xDEADBEEF to 0x100, sel=4'b1111 -> slave sees
//     exact fields; ack reaches m_ack_o[2] only; m_ack_o[1:0]=0.
//  5. Watchdog: TIMEOUT=16, slave never acks -> m_err_o[g]=1 on cycle 16 after
//     stb, s_cyc_o=0, ABORT held until cyc drops, then the next master is granted.
//  6. Ack/timeout race: s_ack_i asserted on exactly cycle TIMEOUT -> ack is
//     delivered, no err, FSM stays in GRANT.

Source files
------------

// File: rtl/wb_ram_arbiter.sv
// Round-robin Wishbone B3 arbiter sharing one slave port among NUM_MASTERS masters.
// The grant is held for a whole cycle (bursts included); an optional watchdog aborts stalls.
module wb_ram_arbiter #(
  parameter int unsigned NUM_MASTERS = 3,
  parameter int unsigned AW          = 32,
  parameter int unsigned DW          = 32,
  parameter int unsigned TIMEOUT     = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_MASTERS*AW-1:0]   m_adr_i,
  input  logic [NUM_MASTERS*DW-1:0]   m_dat_i,
  input  logic [NUM_MASTERS*DW/8-1:0] m_sel_i,
  input  logic [NUM_MASTERS-1:0]      m_we_i,
  input  logic [NUM_MASTERS-1:0]      m_cyc_i,
  input  logic [NUM_MASTERS-1:0]      m_stb_i,
  input  logic [NUM_MASTERS*3-1:0]    m_cti_i,
  input  logic [NUM_MASTERS*2-1:0]    m_bte_i,
  output logic [DW-1:0]               m_dat_o,
  output logic [NUM_MASTERS-1:0]      m_ack_o,
  output logic [NUM_MASTERS-1:0]      m_err_o,
  output logic [NUM_MASTERS-1:0]      m_rty_o,
  output logic [AW-1:0]               s_adr_o,
  output logic [DW-1:0]               s_dat_o,
  output logic [DW/8-1:0]             s_sel_o,
  output logic                        s_we_o,
  output logic [2:0]                  s_cti_o,
  output logic [1:0]                  s_bte_o,
  output logic                        s_cyc_o,
  output logic                        s_stb_o,
  input  logic [DW-1:0]               s_dat_i,
  input  logic                        s_ack_i,
  input  logic                        s_err_i,
  input  logic                        s_rty_i,
  output logic [NUM_MASTERS-1:0]      grant_o
);

  localparam int unsigned SW      = DW / 8;
  localparam int unsigned IdxW    = $clog2(NUM_MASTERS);
  localparam int unsigned WdW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WdW-1:0] WdLimit = WdW'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StGrant, StAbort} state_e;

  state_e                 state_q;
  logic [NUM_MASTERS-1:0] grant_q;
  logic [IdxW-1:0]        last_q;
  logic [WdW-1:0]         wdog_q;

  logic                   pick_valid;
  logic [NUM_MASTERS-1:0] pick_oh;
  int                     pick_j;
  logic [IdxW-1:0]        gidx;
  logic                   cyc_g, stb_g, term, wd_fire;

  // Search upward from last+1, wrapping, for the first master with cyc high.
  always_comb begin
    pick_valid = 1'b0;
    pick_oh    = '0;
    pick_j     = 0;
    for (int i = 1; i <= int'(NUM_MASTERS); i++) begin
      pick_j = int'(last_q) + i;
      if (pick_j >= int'(NUM_MASTERS)) pick_j = pick_j - int'(NUM_MASTERS);
      if (!pick_valid && m_cyc_i[pick_j]) begin
        pick_valid      = 1'b1;
        pick_oh[pick_j] = 1'b1;
      end
    end
  end

  always_comb begin
    gidx = '0;
    for (int k = 0; k < int'(NUM_MASTERS); k++) begin
      if (grant_q[k]) gidx = IdxW'(k);
    end
  end

  assign cyc_g = |(m_cyc_i & grant_q);
  assign stb_g = |(m_stb_i & grant_q);
  assign term  = s_ack_i | s_err_i | s_rty_i;
  // A termination in the limit cycle beats the watchdog.
  assign wd_fire = (TIMEOUT > 0) && (state_q == StGrant) && stb_g && !term &&
                   (wdog_q == WdLimit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      grant_q <= '0;
      last_q  <= IdxW'(NUM_MASTERS - 1);
      wdog_q  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          wdog_q <= '0;
          if (pick_valid) begin
            grant_q <= pick_oh;
            state_q <= StGrant;
          end
        end
        StGrant: begin
          if (!cyc_g) begin
            state_q <= StIdle;
            grant_q <= '0;
            last_q  <= gidx;
            wdog_q  <= '0;
          end else if (wd_fire) begin
            state_q <= StAbort;
            wdog_q  <= '0;
          end else if (term || !stb_g) begin
            wdog_q <= '0;
          end else if (wdog_q != WdLimit) begin
            wdog_q <= wdog_q + WdW'(1);
          end
        end
        StAbort: begin
          wdog_q <= '0;
          if (!cyc_g) begin
            state_q <= StIdle;
            grant_q <= '0;
            last_q  <= gidx;
          end
        end
        default: begin
          state_q <= StIdle;
          grant_q <= '0;
          wdog_q  <= '0;
        end
      endcase
    end
  end

  assign grant_o = grant_q;

  // Fields are zero outside GRANT so nothing undefined reaches the slave or masters.
  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    s_cti_o = '0;
    s_bte_o = '0;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    m_dat_o = '0;
    m_ack_o = '0;
    m_err_o = '0;
    m_rty_o = '0;
    if (state_q == StGrant) begin
      for (int k = 0; k < int'(NUM_MASTERS); k++) begin
        if (grant_q[k]) begin
          s_adr_o    = m_adr_i[k*AW +: AW];
          s_dat_o    = m_dat_i[k*DW +: DW];
          s_sel_o    = m_sel_i[k*SW +: SW];
          s_we_o     = m_we_i[k];
          s_cti_o    = m_cti_i[k*3 +: 3];
          s_bte_o    = m_bte_i[k*2 +: 2];
          m_ack_o[k] = s_ack_i;
          m_err_o[k] = s_err_i | wd_fire;
          m_rty_o[k] = s_rty_i;
        end
      end
      s_cyc_o = cyc_g & ~wd_fire;
      s_stb_o = stb_g & ~wd_fire;
      m_dat_o = s_dat_i;
    end
  end

endmodule

// File: tb/tb_wb_ram_arbiter.sv
// Directed bench for wb_ram_arbiter: reset, round-robin order, burst hold, routing,
// watchdog abort, ack/timeout race and asynchronous reset.
module tb_wb_ram_arbiter;

  localparam int N = 3;

  logic          clk;
  logic          rst_n;
  logic [N*32-1:0] m_adr, m_dat;
  logic [N*4-1:0]  m_sel;
  logic [N-1:0]    m_we, m_cyc, m_stb;
  logic [N*3-1:0]  m_cti;
  logic [N*2-1:0]  m_bte;
  logic [31:0]     m_dat_o;
  logic [N-1:0]    m_ack_o, m_err_o, m_rty_o, grant_o;
  logic [31:0]     s_adr_o, s_dat_o;
  logic [3:0]      s_sel_o;
  logic            s_we_o;
  logic [2:0]      s_cti_o;
  logic [1:0]      s_bte_o;
  logic            s_cyc_o, s_stb_o;
  logic [31:0]     s_dat;
  logic            s_ack, s_err, s_rty;

  int tests = 0;
  int fails = 0;

  wb_ram_arbiter #(.NUM_MASTERS(N), .AW(32), .DW(32), .TIMEOUT(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .m_adr_i (m_adr),
    .m_dat_i (m_dat),
    .m_sel_i (m_sel),
    .m_we_i  (m_we),
    .m_cyc_i (m_cyc),
    .m_stb_i (m_stb),
    .m_cti_i (m_cti),
    .m_bte_i (m_bte),
    .m_dat_o (m_dat_o),
    .m_ack_o (m_ack_o),
    .m_err_o (m_err_o),
    .m_rty_o (m_rty_o),
    .s_adr_o (s_adr_o),
    .s_dat_o (s_dat_o),
    .s_sel_o (s_sel_o),
    .s_we_o  (s_we_o),
    .s_cti_o (s_cti_o),
    .s_bte_o (s_bte_o),
    .s_cyc_o (s_cyc_o),
    .s_stb_o (s_stb_o),
    .s_dat_i (s_dat),
    .s_ack_i (s_ack),
    .s_err_i (s_err),
    .s_rty_i (s_rty),
    .grant_o (grant_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Granted master k gets a one-beat ack, then drops cyc; expect one idle cycle.
  task automatic single(input int k);
    s_ack = 1'b1;
    #1;
    chk("single_ack", 64'(m_ack_o), 64'(1 << k));
    tick();
    s_ack    = 1'b0;
    m_cyc[k] = 1'b0;
    m_stb[k] = 1'b0;
    #1;
    chk("single_hold", 64'(grant_o), 64'(1 << k));
    tick();
    #1;
    chk("single_idle", 64'(grant_o), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL bench_timeout: simulation exceeded its time limit");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst_n = 1'b0;
    m_adr = '0; m_dat = '0; m_sel = '0; m_we = '0;
    m_cti = '0; m_bte = '0;
    m_cyc = 3'b111;
    m_stb = 3'b111;
    s_dat = 32'hA5A5_0001;
    s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;

    // Reset with all masters requesting
    #1;
    chk("rst_grant", 64'(grant_o), 64'd0);
    chk("rst_scyc", 64'(s_cyc_o), 64'd0);
    chk("rst_sstb", 64'(s_stb_o), 64'd0);
    chk("rst_err", 64'(m_err_o), 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    #1;
    chk("first_grant_m0", 64'(grant_o), 64'b001);
    chk("grant_dat_bcast", 64'(m_dat_o), 64'hA5A5_0001);

    // Contention: order 0,1,2,0
    single(0);
    m_cyc[0] = 1'b1;
    m_stb[0] = 1'b1;
    tick(); #1;
    chk("rr_grant_m1", 64'(grant_o), 64'b010);
    single(1);
    tick(); #1;
    chk("rr_grant_m2", 64'(grant_o), 64'b100);
    single(2);
    tick(); #1;
    chk("rr_grant_m0_again", 64'(grant_o), 64'b001);
    single(0);

    // Burst on master1 while master0 waits (last = 0, so master1 wins)
    m_cyc = 3'b011;
    m_stb = 3'b011;
    m_cti[3 +: 3] = 3'b010;
    m_adr[32 +: 32] = 32'h0000_0200;
    tick(); #1;
    chk("burst_grant_m1", 64'(grant_o), 64'b010);
    for (int b = 0; b < 4; b++) begin
      m_cti[3 +: 3]   = (b == 3) ? 3'b111 : 3'b010;
      m_adr[32 +: 32] = 32'h0000_0200 + 32'(4 * b);
      s_ack = 1'b1;
      #1;
      chk("burst_ack", 64'(m_ack_o), 64'b010);
      chk("burst_cti", 64'(s_cti_o), (b == 3) ? 64'b111 : 64'b010);
      chk("burst_adr", 64'(s_adr_o), 64'h200 + 64'(4 * b));
      tick();
    end
    s_ack    = 1'b0;
    m_cyc[1] = 1'b0;
    m_stb[1] = 1'b0;
    #1;
    chk("burst_hold_after_last", 64'(grant_o), 64'b010);
    tick(); #1;
    chk("burst_idle", 64'(grant_o), 64'd0);
    tick(); #1;
    chk("burst_then_m0", 64'(grant_o), 64'b001);
    single(0);

    // Routing: master2 write, other masters carry junk fields
    m_adr[0 +: 32]  = 32'h1111_1111;
    m_dat[0 +: 32]  = 32'h2222_2222;
    m_adr[32 +: 32] = 32'h3333_3333;
    m_sel[0 +: 8]   = 8'h55;
    chk("idle_adr_zero", 64'(s_adr_o), 64'd0);
    m_adr[64 +: 32] = 32'h0000_0100;
    m_dat[64 +: 32] = 32'hDEAD_BEEF;
    m_sel[8 +: 4]   = 4'b1111;
    m_we[2]         = 1'b1;
    m_cti[6 +: 3]   = 3'b000;
    m_cyc[2]        = 1'b1;
    m_stb[2]        = 1'b1;
    tick(); #1;
    chk("route_grant_m2", 64'(grant_o), 64'b100);
    chk("route_adr", 64'(s_adr_o), 64'h100);
    chk("route_dat", 64'(s_dat_o), 64'hDEAD_BEEF);
    chk("route_sel", 64'(s_sel_o), 64'hF);
    chk("route_we", 64'(s_we_o), 64'd1);
    chk("route_cyc", 64'(s_cyc_o), 64'd1);
    single(2);
    m_we[2] = 1'b0;

    // Watchdog: master0 stalls (last = 2), master1 waiting
    m_cyc = 3'b011;
    m_stb = 3'b011;
    tick(); #1;
    chk("wd_grant_m0", 64'(grant_o), 64'b001);
    repeat (15) tick();
    #1;
    chk("wd_no_err_c15", 64'(m_err_o), 64'd0);
    chk("wd_cyc_c15", 64'(s_cyc_o), 64'd1);
    tick(); #1;
    chk("wd_err_c16", 64'(m_err_o), 64'b001);
    chk("wd_cyc_low_c16", 64'(s_cyc_o), 64'd0);
    chk("wd_stb_low_c16", 64'(s_stb_o), 64'd0);
    tick(); #1;
    chk("wd_err_pulse_end", 64'(m_err_o), 64'd0);
    chk("abort_cyc_low", 64'(s_cyc_o), 64'd0);
    repeat (3) tick();
    #1;
    chk("abort_grant_held", 64'(grant_o), 64'b001);
    chk("abort_cyc_still_low", 64'(s_cyc_o), 64'd0);
    m_cyc[0] = 1'b0;
    m_stb[0] = 1'b0;
    tick(); #1;
    chk("abort_idle", 64'(grant_o), 64'd0);
    tick(); #1;
    chk("abort_next_m1", 64'(grant_o), 64'b010);
    single(1);

    // Ack arrives exactly in the limit cycle (last = 1, master2 requests)
    m_cyc[2] = 1'b1;
    m_stb[2] = 1'b1;
    tick(); #1;
    chk("race_grant_m2", 64'(grant_o), 64'b100);
    repeat (16) tick();
    s_ack = 1'b1;
    #1;
    chk("race_ack", 64'(m_ack_o), 64'b100);
    chk("race_no_err", 64'(m_err_o), 64'd0);
    chk("race_cyc", 64'(s_cyc_o), 64'd1);
    tick();
    s_ack = 1'b0;
    #1;
    chk("race_stay_grant", 64'(grant_o), 64'b100);
    chk("race_stay_cyc", 64'(s_cyc_o), 64'd1);
    chk("race_err_after", 64'(m_err_o), 64'd0);
    m_cyc[2] = 1'b0;
    m_stb[2] = 1'b0;
    tick(); tick(); #1;
    chk("race_idle", 64'(grant_o), 64'd0);

    // Asynchronous reset between clock edges
    m_cyc[0] = 1'b1;
    m_stb[0] = 1'b1;
    tick(); #1;
    chk("async_pre_grant", 64'(grant_o), 64'b001);
    s_ack = 1'b1;
    #1;
    chk("async_pre_ack", 64'(m_ack_o), 64'b001);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_grant", 64'(grant_o), 64'd0);
    chk("async_scyc", 64'(s_cyc_o), 64'd0);
    chk("async_ack", 64'(m_ack_o), 64'd0);
    s_ack = 1'b0;
    m_cyc = '0;
    m_stb = '0;
    tick();
    rst_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
